// File: rtl/seven_seg_pkg.sv
// Shared constants and the scan-state type for the seven-segment scanner.
package seven_seg_pkg;

    localparam int         BCD_W     = 4;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } scan_state_t;

endpackage

// File: rtl/seven_segment_decoder.sv
// BCD nibble to segment pattern (a..g, a is MSB, active-high); 10-15 show a dash.
module seven_segment_decoder
    import seven_seg_pkg::*;
(
    input  logic [BCD_W-1:0] i_bcd,
    output logic [6:0]       o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = 7'b1111110;
            4'd1:    o_seg = 7'b0110000;
            4'd2:    o_seg = 7'b1101101;
            4'd3:    o_seg = 7'b1111001;
            4'd4:    o_seg = 7'b0110011;
            4'd5:    o_seg = 7'b1011011;
            4'd6:    o_seg = 7'b1011111;
            4'd7:    o_seg = 7'b1110000;
            4'd8:    o_seg = 7'b1111111;
            4'd9:    o_seg = 7'b1111011;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed seven-segment scanner with frame-aligned (tear-free) updates,
// per-slot blanking gap and optional leading-zero blanking.
module seven_segment_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 1000,
    parameter int BLANK      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [BCD_W*NUM_DIGITS-1:0] in_bcd,
    input  logic [NUM_DIGITS-1:0]       in_dp,
    input  logic                        lz_blank,
    output logic [6:0]                  seg,
    output logic                        dp,
    output logic [NUM_DIGITS-1:0]       an,
    output logic                        frame_done
);

    localparam int                CNT_W     = $clog2(DIV);
    localparam int                DIG_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_BLANK = CNT_W'(BLANK);
    localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(NUM_DIGITS - 1);
    localparam scan_state_t       SLOT_START = (BLANK == 0) ? seven_seg_pkg::SHOW
                                                            : seven_seg_pkg::BLANK;

    scan_state_t                 r_state, w_state_nxt;
    logic [CNT_W-1:0]            r_cnt, w_cnt_nxt;
    logic [DIG_W-1:0]            r_digit, w_digit_nxt;
    logic                        r_full;
    logic [BCD_W*NUM_DIGITS-1:0] r_shadow_bcd, r_disp_bcd, w_disp_bcd_nxt;
    logic [NUM_DIGITS-1:0]       r_shadow_dp, r_disp_dp, w_disp_dp_nxt;
    logic [6:0]                  r_seg;
    logic                        r_dp, r_frame_done;
    logic [NUM_DIGITS-1:0]       r_an;

    logic                        w_xfer, w_commit, w_show;
    logic [NUM_DIGITS-1:0]       w_lz_mask, w_an_onehot;
    logic [BCD_W-1:0]            w_nibble;
    logic                        w_dp_sel, w_lz_sel;
    logic [6:0]                  w_dec_seg;

    assign in_ready   = !r_full;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign an         = r_an;
    assign frame_done = r_frame_done;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_digit_nxt = r_digit;
        if (!enable) begin
            w_state_nxt = seven_seg_pkg::IDLE;
            w_cnt_nxt   = '0;
            w_digit_nxt = '0;
        end else if (r_state == seven_seg_pkg::IDLE) begin
            w_state_nxt = SLOT_START;
            w_cnt_nxt   = '0;
            w_digit_nxt = '0;
        end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = SLOT_START;
            w_cnt_nxt   = '0;
            w_digit_nxt = (r_digit == DIG_LAST) ? '0 : r_digit + 1'b1;
        end else begin
            w_cnt_nxt   = r_cnt + 1'b1;
            w_state_nxt = (w_cnt_nxt < CNT_BLANK) ? seven_seg_pkg::BLANK
                                                  : seven_seg_pkg::SHOW;
        end
    end

    // Commit is forwarded so the first slot after a boundary already decodes the new word.
    assign w_xfer         = in_valid && !r_full;
    assign w_commit       = r_full && (r_frame_done || r_state == seven_seg_pkg::IDLE);
    assign w_disp_bcd_nxt = w_commit ? r_shadow_bcd : r_disp_bcd;
    assign w_disp_dp_nxt  = w_commit ? r_shadow_dp  : r_disp_dp;
    assign w_show         = (w_state_nxt == seven_seg_pkg::SHOW);

    always_comb begin
        logic zero_run;
        zero_run  = 1'b1;
        w_lz_mask = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run     = zero_run && (w_disp_bcd_nxt[BCD_W*i +: BCD_W] == '0);
            w_lz_mask[i] = lz_blank && zero_run;
        end
    end

    always_comb begin
        w_nibble    = '0;
        w_dp_sel    = 1'b0;
        w_lz_sel    = 1'b0;
        w_an_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_digit_nxt == DIG_W'(i)) begin
                w_nibble       = w_disp_bcd_nxt[BCD_W*i +: BCD_W];
                w_dp_sel       = w_disp_dp_nxt[i];
                w_lz_sel       = w_lz_mask[i];
                w_an_onehot[i] = 1'b1;
            end
        end
    end

    seven_segment_decoder u_decoder (
        .i_bcd (w_nibble),
        .o_seg (w_dec_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= seven_seg_pkg::IDLE;
            r_cnt        <= '0;
            r_digit      <= '0;
            r_full       <= 1'b0;
            r_disp_bcd   <= '0;
            r_disp_dp    <= '0;
            r_seg        <= SEG_BLANK;
            r_dp         <= 1'b0;
            r_an         <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_digit      <= w_digit_nxt;
            r_disp_bcd   <= w_disp_bcd_nxt;
            r_disp_dp    <= w_disp_dp_nxt;
            if (w_xfer) begin
                r_full <= 1'b1;
            end else if (w_commit) begin
                r_full <= 1'b0;
            end
            r_an         <= w_show ? w_an_onehot : '0;
            r_seg        <= (w_show && !w_lz_sel) ? w_dec_seg : SEG_BLANK;
            r_dp         <= w_show && w_dp_sel;
            r_frame_done <= (w_state_nxt != seven_seg_pkg::IDLE) &&
                            (w_cnt_nxt == CNT_LAST) && (w_digit_nxt == DIG_LAST);
        end
    end

    // Shadow payload is qualified by r_full, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_shadow_bcd <= in_bcd;
            r_shadow_dp  <= in_dp;
        end
    end

endmodule
